// File: rtl/rooth_sig_dump.sv
// Compliance-run monitor: snoops data-memory writes for the signature bounds and the
// end flag, then reads the signature region back and streams it over valid/ready.
// Optional run-phase timeout is compiled in with `define RSD_TIMEOUT_EN.
module rooth_sig_dump #(
    parameter int          AW          = 32,
    parameter int          DW          = 32,
    parameter logic [AW-1:0] BEGIN_ADDR = 'h8,
    parameter logic [AW-1:0] END_ADDR   = 'hC,
    parameter logic [AW-1:0] FLAG_ADDR  = 'h10,
    parameter logic [DW-1:0] END_VALUE  = 'h1,
    parameter int unsigned TIMEOUT_CYC = 15000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_waddr_i,
    input  logic [DW-1:0] mem_wdata_i,
    output logic          rd_req_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [DW-1:0] rd_data_i,
    output logic          sig_vld_o,
    output logic [DW-1:0] sig_data_o,
    output logic          sig_last_o,
    input  logic          sig_rdy_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_o,
    output logic [31:0]   cyc_cnt_o
);

    typedef enum logic [2:0] {
        S_RUN,
        S_CHECK,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
`ifdef RSD_TIMEOUT_EN
        , S_TOUT
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] begin_q, begin_d;
    logic [AW-1:0] end_q,   end_d;
    logic [AW-1:0] cur_q,   cur_d;
    logic [DW-1:0] data_q,  data_d;
    logic          vld_q,   vld_d;
    logic          last_q,  last_d;
    logic [31:0]   cnt_q,   cnt_d;

    logic [AW-1:0] wdata_addr;
    logic          snoop_en;
    logic          begin_hit;
    logic          end_hit;
    logic          flag_hit;
    logic [AW-1:0] begin_w;
    logic [AW-1:0] end_w;
    logic [AW:0]   cur_inc;
    logic          last_w;
    logic [1:0]    unused_addr_bits;

    // Signature bounds arrive as data words; fit them to the address width.
    if (DW >= AW) begin : g_wide
        assign wdata_addr = mem_wdata_i[AW-1:0];
    end else begin : g_narrow
        assign wdata_addr = {{(AW-DW){1'b0}}, mem_wdata_i};
    end

    assign unused_addr_bits = mem_waddr_i[1:0];

    assign snoop_en  = mem_we_i && (state_q == S_RUN);
    assign begin_hit = snoop_en && (mem_waddr_i[AW-1:2] == BEGIN_ADDR[AW-1:2]);
    assign end_hit   = snoop_en && (mem_waddr_i[AW-1:2] == END_ADDR[AW-1:2]);
    assign flag_hit  = snoop_en && (mem_waddr_i[AW-1:2] == FLAG_ADDR[AW-1:2])
                       && (mem_wdata_i == END_VALUE);

    assign begin_w = {begin_q[AW-1:2], 2'b00};
    assign end_w   = {end_q[AW-1:2], 2'b00};

    // The carry out of cur+4 means the region reaches the top of the address space.
    assign cur_inc = {1'b0, cur_q} + {{(AW-2){1'b0}}, 3'b100};
    assign last_w  = cur_inc[AW] || (cur_inc[AW-1:0] >= end_q);

    always_comb begin
        state_d = state_q;
        begin_d = begin_q;
        end_d   = end_q;
        cur_d   = cur_q;
        data_d  = data_q;
        vld_d   = vld_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (begin_hit) begin
                    begin_d = wdata_addr;
                end
                if (end_hit) begin
                    end_d = wdata_addr;
                end
                if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (flag_hit) begin
                    state_d = S_CHECK;
                end
`ifdef RSD_TIMEOUT_EN
                else if (cnt_q >= 32'(TIMEOUT_CYC)) begin
                    state_d = S_TOUT;
                end
`endif
            end
            S_CHECK: begin
                begin_d = begin_w;
                end_d   = end_w;
                if (begin_w >= end_w) begin
                    state_d = S_DONE;
                end else begin
                    cur_d   = begin_w;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                data_d  = rd_data_i;
                vld_d   = 1'b1;
                last_d  = last_w;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (sig_rdy_i) begin
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    cur_d   = cur_inc[AW-1:0];
                    state_d = last_q ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
`ifdef RSD_TIMEOUT_EN
            S_TOUT: begin
                state_d = S_TOUT;
            end
`endif
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            begin_q <= '0;
            end_q   <= '0;
            cur_q   <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            begin_q <= begin_d;
            end_q   <= end_d;
            cur_q   <= cur_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rd_req_o   = (state_q == S_READ);
    assign rd_addr_o  = (state_q == S_READ) ? cur_q : '0;
    assign sig_vld_o  = vld_q;
    assign sig_data_o = data_q;
    assign sig_last_o = last_q;
    assign busy_o     = (state_q == S_CHECK) || (state_q == S_READ) ||
                        (state_q == S_WAIT)  || (state_q == S_SEND);
    assign done_o     = (state_q == S_DONE);
    assign cyc_cnt_o  = cnt_q;
`ifdef RSD_TIMEOUT_EN
    assign timeout_o  = (state_q == S_TOUT);
`else
    assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_rooth_sig_dump.sv
// Randomized bench for rooth_sig_dump: a reference model derives the expected
// signature stream from the snooped bounds and a deterministic memory image.
module tb_rooth_sig_dump;

    localparam int          AW        = 32;
    localparam int          DW        = 32;
    localparam logic [31:0] A_BEGIN   = 32'h8;
    localparam logic [31:0] A_END     = 32'hC;
    localparam logic [31:0] A_FLAG    = 32'h10;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_we_i;
    logic [AW-1:0] mem_waddr_i;
    logic [DW-1:0] mem_wdata_i;
    logic          rd_req_o;
    logic [AW-1:0] rd_addr_o;
    logic [DW-1:0] rd_data_i;
    logic          sig_vld_o;
    logic [DW-1:0] sig_data_o;
    logic          sig_last_o;
    logic          sig_rdy_i;
    logic          busy_o;
    logic          done_o;
    logic          timeout_o;
    logic [31:0]   cyc_cnt_o;

    int n_checks = 0;
    int n_bad    = 0;
    int run_ticks;

    always #5 clk = ~clk;

    rooth_sig_dump #(
        .AW(AW), .DW(DW),
        .BEGIN_ADDR(A_BEGIN), .END_ADDR(A_END), .FLAG_ADDR(A_FLAG),
        .END_VALUE(32'h1), .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .sig_vld_o(sig_vld_o), .sig_data_o(sig_data_o), .sig_last_o(sig_last_o),
        .sig_rdy_i(sig_rdy_i), .busy_o(busy_o), .done_o(done_o),
        .timeout_o(timeout_o), .cyc_cnt_o(cyc_cnt_o)
    );

    // Memory image: the test-plan words at 0x200, an address hash elsewhere.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h200: return 32'hA;
            32'h204: return 32'hB;
            32'h208: return 32'hC;
            default: return {a[15:0], ~a[31:16]} ^ 32'h3C3C_0000;
        endcase
    endfunction

    // Read port answers one cycle after the request; garbage otherwise.
    always @(posedge clk) begin
        rd_data_i <= rd_req_o ? mem_val(rd_addr_o) : $urandom();
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_run();
        tick();
        run_ticks++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_we_i = 1'b0;
        sig_rdy_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        run_ticks = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_we_i = 1'b1;
        mem_waddr_i = a;
        mem_wdata_i = d;
        tick_run();
        mem_we_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_vld"},  32'(sig_vld_o), 0);
        check_val({tag, "_data"}, sig_data_o, 0);
        check_val({tag, "_last"}, 32'(sig_last_o), 0);
        check_val({tag, "_busy"}, 32'(busy_o), 0);
        check_val({tag, "_done"}, 32'(done_o), 0);
        check_val({tag, "_req"},  32'(rd_req_o), 0);
        check_val({tag, "_addr"}, rd_addr_o, 0);
        check_val({tag, "_tout"}, 32'(timeout_o), 0);
        check_val({tag, "_cnt"},  cyc_cnt_o, 0);
    endtask

    // mode: 0 = ready always high, 1 = random ready, 2 = stall word stall_idx
    task automatic run_dump(input string name, input logic [31:0] b, input logic [31:0] e,
                            input int mode, input int stall_idx, input int stall_len,
                            input bit late_wr, input int abort_idx);
        logic [31:0] exp_q[$];
        logic [31:0] bt, et, held_data;
        logic        held_last, rdy;
        longint      a;
        int          idx, cyc, hs_cyc, held, n;
        bit          seen, finished;

        bt = b & ~32'h3;
        et = e & ~32'h3;
        for (a = longint'(bt); a < longint'(et); a += 4) begin
            exp_q.push_back(mem_val(a[31:0]));
        end
        n = exp_q.size();

        // Decoy writes: stale bounds, unrelated address, wrong flag value.
        wr(A_BEGIN | 32'($urandom_range(0, 3)), $urandom());
        wr(A_END | 32'($urandom_range(0, 3)), $urandom());
        wr(32'h40, 32'h1);
        wr(A_FLAG, 32'h2);
        check_val("wrong_flag_idle", 32'(busy_o), 0);
        wr(A_BEGIN | 32'($urandom_range(0, 3)), b);
        wr(A_END | 32'($urandom_range(0, 3)), e);
        wr(A_FLAG, 32'h1);
        check_val("cnt_at_flag", cyc_cnt_o, 32'(run_ticks));
        check_val("busy_check", 32'(busy_o), 1);

        cyc = 1; idx = 0; held = 0; hs_cyc = 1; seen = 0; finished = 0;
        held_data = '0; held_last = 1'b0;
        while (cyc < 400 && !finished) begin
            mem_we_i = 1'b0;
            if (late_wr && cyc == 2) begin
                mem_we_i = 1'b1; mem_waddr_i = A_BEGIN; mem_wdata_i = b + 32'h100;
            end else if (late_wr && cyc == 3) begin
                mem_we_i = 1'b1; mem_waddr_i = A_FLAG; mem_wdata_i = 32'h1;
            end else if (late_wr && cyc == 4) begin
                mem_we_i = 1'b1; mem_waddr_i = A_END; mem_wdata_i = e + 32'h40;
            end
            if (rd_req_o) begin
                check_val("rd_addr", rd_addr_o, bt + 32'(4 * idx));
            end
            if (done_o) begin
                check_val("words_emitted", 32'(idx), 32'(n));
                check_val("done_lat", 32'(cyc), 32'(hs_cyc + 1));
                check_val("done_vld", 32'(sig_vld_o), 0);
                check_val("cnt_hold", cyc_cnt_o, 32'(run_ticks));
                finished = 1;
            end else if (sig_vld_o) begin
                if (!seen) begin
                    if (idx >= n) begin
                        check_val("word_count", 32'(idx + 1), 32'(n));
                    end else begin
                        check_val("sig_data", sig_data_o, exp_q[idx]);
                        check_val("sig_last", 32'(sig_last_o), 32'(idx == n - 1));
                        if (mode == 0) begin
                            check_val("vld_lat", 32'(cyc), 32'(4 + 3 * idx));
                        end
                    end
                    seen = 1;
                    held_data = sig_data_o;
                    held_last = sig_last_o;
                end else begin
                    check_val("hold_data", sig_data_o, held_data);
                    check_val("hold_last", 32'(sig_last_o), 32'(held_last));
                end
                if (abort_idx == idx) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    mem_we_i = 1'b0;
                    run_ticks = 0;
                    check_all_zero("abort");
                    $display("dump %s: aborted at word %0d", name, idx);
                    return;
                end
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: rdy = !(idx == stall_idx && held < stall_len);
                endcase
                sig_rdy_i = rdy;
                if (rdy) begin
                    idx++;
                    seen = 0;
                    held = 0;
                    hs_cyc = cyc;
                end else begin
                    held++;
                end
            end else begin
                sig_rdy_i = 1'($urandom_range(0, 1));
            end
            if (!finished) begin
                tick();
                cyc++;
            end
        end
        mem_we_i = 1'b0;
        if (!finished) begin
            check_val("dump_timeout", 32'(done_o), 1);
        end
        check_val("tout_low", 32'(timeout_o), 0);
        $display("dump %s: begin=%h end=%h words=%0d/%0d cycles=%0d", name, b, e, idx, n, cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_we_i = 1'b0;
        mem_waddr_i = '0;
        mem_wdata_i = '0;
        sig_rdy_i = 1'b1;
        do_reset();
        check_all_zero("reset");

`ifdef RSD_TIMEOUT_EN
        repeat (50) tick();
        check_val("tout_c50", 32'(timeout_o), 0);
        tick();
        check_val("tout_c51", 32'(timeout_o), 1);
        check_val("tout_done", 32'(done_o), 0);
        $display("timeout: raised at cycle 51");
`else
        repeat (60) tick();
        check_val("idle_tout", 32'(timeout_o), 0);
        check_val("idle_busy", 32'(busy_o), 0);
        check_val("idle_cnt", cyc_cnt_o, 32'd60);
        $display("idle: 60 cycles in run, counter=%0d", cyc_cnt_o);
`endif

        do_reset();
        run_dump("empty", 32'h100, 32'h100, 0, 0, 0, 1'b0, -1);
        do_reset();
        run_dump("inverted", 32'h300, 32'h2F0, 0, 0, 0, 1'b0, -1);
        do_reset();
        run_dump("three", 32'h200, 32'h20C, 0, 0, 0, 1'b0, -1);
        do_reset();
        run_dump("backpressure", 32'h200, 32'h20C, 2, 1, 5, 1'b0, -1);
        do_reset();
        run_dump("late_writes", 32'h200, 32'h20C, 0, 0, 0, 1'b1, -1);
        do_reset();
        run_dump("abort", 32'h200, 32'h20C, 2, 1, 2, 1'b0, 1);
        run_dump("restart", 32'h200, 32'h20C, 0, 0, 0, 1'b0, -1);
        do_reset();
        run_dump("unaligned", 32'h203, 32'h20E, 0, 0, 0, 1'b0, -1);
        do_reset();
        run_dump("top", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 0, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] rb, re;
            rb = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            re = rb + 32'($urandom_range(0, 56)) - 32'd8;
            do_reset();
            run_dump("random", rb, re, (i % 2 == 0) ? 1 : 0, 0, 0, 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/rooth_sig_dump.md
# rooth_sig_dump

Synthesizable compliance-run monitor for the rooth SoC. Snoops the data-memory write port for the signature-begin, signature-end and end-flag words. Once the end flag is written, it reads the signature region back through a dedicated memory read port and streams it out word by word over a valid/ready interface. It replaces hierarchical-peek end-of-test detection with a parametrised block usable in simulation, FPGA and emulation.

## Interface

- AW, 32, address width (byte address)
- DW, 32, data / signature word width
- BEGIN_ADDR, 32'h8, byte address of signature-begin word (data-memory word 2)
- END_ADDR, 32'hC, byte address of signature-end word (word 3)
- FLAG_ADDR, 32'h10, byte address of end-flag word (word 4)
- END_VALUE, 32'h1, flag value that ends the run
- TIMEOUT_CYC, 15000, run-phase cycle limit (used only with RSD_TIMEOUT_EN)

Ports:

- clk  in  1  clock; single domain, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- mem_we_i  in  1  data-memory write strobe (snoop)
- mem_waddr_i  in  AW  data-memory write byte address
- mem_wdata_i  in  DW  data-memory write data
- rd_req_o  out  1  read request to signature memory
- rd_addr_o  out  AW  read byte address, word aligned
- rd_data_i  in  DW  read data, valid exactly 1 cycle after rd_req_o
- sig_vld_o  out  1  signature word valid
- sig_data_o  out  DW  signature word
- sig_last_o  out  1  final word of the dump, qualified by sig_vld_o
- sig_rdy_i  in  1  downstream ready
- busy_o  out  1  dump in progress
- done_o  out  1  dump complete (sticky until rst)
- timeout_o  out  1  run timed out (sticky until rst)
- cyc_cnt_o  out  32  run-phase cycle count; saturates at 32'hFFFF_FFFF

## Operation

- States: RUN, CHECK, READ, WAIT, SEND, DONE, TOUT.
- RUN:
  - A write with mem_waddr_i[AW-1:2] == BEGIN_ADDR[AW-1:2] latches begin_q; the END_ADDR match latches end_q. The last write wins.
  - A write to FLAG_ADDR with data == END_VALUE moves to CHECK. Any other value is ignored.
  - cyc_cnt_o increments every RUN cycle.
- CHECK:
  - begin_q and end_q are word-truncated (low 2 bits cleared).
  - If begin_q >= end_q, go to DONE with zero words emitted.
  - Otherwise cur_q = begin_q; go to READ.
- READ: rd_req_o=1, rd_addr_o=cur_q for one cycle; go to WAIT.
- WAIT:
  - Register rd_data_i into sig_data_o; sig_vld_o=1.
  - sig_last_o = (cur_q + 4 >= end_q).
  - Go to SEND.
- SEND:
  - Hold sig_vld_o, sig_data_o and sig_last_o stable until sig_rdy_i.
  - On handshake: cur_q += 4; go to DONE if last, else READ.
- DONE and TOUT are terminal; only rst exits them.
- Snooped writes outside RUN are ignored. This covers BEGIN, END and FLAG writes alike.
- Address arithmetic is AW bits, unsigned; cur_q + 4 wrapping past 2^AW counts as last.

## Timing

- Reset values: all outputs 0; state RUN; begin_q = end_q = cur_q = 0.
- Flag write at cycle N gives CHECK at N+1 and rd_req_o at N+2. The first sig_vld_o appears at N+4.
- With sig_rdy_i held high, one word every 3 cycles: READ, WAIT, SEND.
- done_o rises the cycle after the last handshake, or the cycle after CHECK when the region is empty.
- busy_o = 1 in CHECK, READ, WAIT and SEND.
- rst in any state: state returns to RUN next cycle; sig_vld_o drops; a partial dump is abandoned; the counter clears.
- A flag write and a timeout in the same cycle: the flag wins and the block goes to CHECK.

## Configuration

- Macro RSD_TIMEOUT_EN.
- Defined: when cyc_cnt_o reaches TIMEOUT_CYC in RUN, the state moves to TOUT next cycle; timeout_o=1; no dump is performed.
- Undefined: the TOUT state and compare logic are absent; timeout_o is tied 0; RUN waits indefinitely.

## Test plan

- Empty region:
  - Stimulus: write 0x100 to BEGIN, 0x100 to END, then 0x1 to FLAG.
  - Expected: no sig_vld_o; done_o high 2 cycles after the flag write.
- Three-word region with rdy always high:
  - Stimulus: BEGIN=0x200, END=0x20C; memory holds 0xA, 0xB, 0xC; flag written.
  - Expected: words 0xA, 0xB, 0xC at 3-cycle spacing, first word 4 cycles after the flag; sig_last_o only on 0xC; then done_o.
- Backpressure:
  - Stimulus: same region, sig_rdy_i low for 5 cycles on the second word.
  - Expected: 0xB held stable for all 5 cycles; output order unchanged.
- Wrong flag value, late writes:
  - Stimulus: FLAG written with 0x2, then 0x1; after that, BEGIN rewritten during the dump.
  - Expected: only 0x1 triggers the dump; the dump uses the original BEGIN.
- Timeout (RSD_TIMEOUT_EN, TIMEOUT_CYC=50):
  - Stimulus: no flag write.
  - Expected: timeout_o rises at cycle 51 after reset, and done_o stays 0.
- Reset mid-dump:
  - Stimulus: rst pulsed while in SEND.
  - Expected: all outputs 0 next cycle; a new flag write restarts a full dump.
